// File: rtl/note_recorder_pkg.sv
// Shared encodings for the note recorder: FSM states, octave codes, event layout
// and the note-number to one-hot helper used on the replay side.
package note_recorder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REC   = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_PLAY  = 2'd3;

  localparam logic [1:0] OCT_MID  = 2'd0;
  localparam logic [1:0] OCT_HIGH = 2'd1;
  localparam logic [1:0] OCT_LOW  = 2'd2;

  // Event word, LSB first: dur[DUR_W-1:0], oct at DUR_W, note at DUR_W+OCT_W
  localparam int NOTE_W = 3;
  localparam int OCT_W  = 2;
  localparam int CODE_W = NOTE_W + OCT_W;

  function automatic logic [6:0] note_onehot(input logic [NOTE_W-1:0] note);
    logic [6:0] oh;
    case (note)
      3'd1:    oh = 7'b0000001;
      3'd2:    oh = 7'b0000010;
      3'd3:    oh = 7'b0000100;
      3'd4:    oh = 7'b0001000;
      3'd5:    oh = 7'b0010000;
      3'd6:    oh = 7'b0100000;
      3'd7:    oh = 7'b1000000;
      default: oh = 7'b0000000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/recorder_mem.sv
// Simple dual-port event store: synchronous write, registered read (1-cycle latency).
// Array contents are intentionally not reset.
module recorder_mem #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Array write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r <= DATA_W'(0);
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/note_recorder.sv
// Record-and-replay engine: captures free-mode notes as timed events and
// replays them as a note/octave stream for the tone generator.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int DUR_W    = 6,
  parameter int TICK_DIV = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic              play_start,
  input  logic [6:0]        notes,
  input  logic              ishigher,
  input  logic              islower,
  output logic [6:0]        play_note,
  output logic              play_higher,
  output logic              play_lower,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] cur_idx
);

  localparam int                EVT_W     = CODE_W + DUR_W;
  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  DUR_MAX   = {DUR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);

  // Lowest pressed switch wins; both octave switches together mean middle octave
  function automatic logic [CODE_W-1:0] code_of(input logic [6:0] n, input logic hi, input logic lo);
    logic [NOTE_W-1:0] nt;
    logic [OCT_W-1:0]  oc;
    casez (n)
      7'b??????1: nt = 3'd1;
      7'b?????10: nt = 3'd2;
      7'b????100: nt = 3'd3;
      7'b???1000: nt = 3'd4;
      7'b??10000: nt = 3'd5;
      7'b?100000: nt = 3'd6;
      7'b1000000: nt = 3'd7;
      default:    nt = 3'd0;
    endcase
    case ({hi, lo})
      2'b10:   oc = OCT_HIGH;
      2'b01:   oc = OCT_LOW;
      default: oc = OCT_MID;
    endcase
    return {nt, oc};
  endfunction

  logic [1:0]        state_r, state_nxt_s;
  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_s, tick_clr_s;
  logic [ADDR_W:0]   count_r, count_nxt_s, count_inc_s;
  logic              full_r, full_nxt_s;
  logic [CODE_W-1:0] live_s, cur_r, cur_nxt_s;
  logic [DUR_W-1:0]  dur_r, dur_nxt_s, rem_r, rem_nxt_s;
  logic [ADDR_W-1:0] idx_r, idx_nxt_s, cur_idx_r;
  logic [6:0]        note_r, note_nxt_s;
  logic              hi_r, hi_nxt_s, lo_r, lo_nxt_s;
  logic              recording_r, playing_r, last_s, wr_en_s;
  logic [EVT_W-1:0]  rd_data_s;

  assign live_s      = code_of(notes, ishigher, islower);
  assign count_inc_s = count_r + (ADDR_W+1)'(1);
  assign last_s      = ({1'b0, idx_r} == (count_r - (ADDR_W+1)'(1)));
  assign tick_s      = ((state_r == ST_REC) || (state_r == ST_PLAY)) && (tick_cnt_r == TICK_LAST);

  // Tick divider; frozen outside REC/PLAY so FETCH adds exactly one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= TICK_W'(0);
    end else if (tick_clr_s || tick_s) begin
      tick_cnt_r <= TICK_W'(0);
    end else if ((state_r == ST_REC) || (state_r == ST_PLAY)) begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Next-state, event capture and replay decode
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    full_nxt_s  = full_r;
    cur_nxt_s   = cur_r;
    dur_nxt_s   = dur_r;
    idx_nxt_s   = idx_r;
    rem_nxt_s   = rem_r;
    note_nxt_s  = note_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    tick_clr_s  = 1'b0;
    wr_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        note_nxt_s = 7'd0;
        hi_nxt_s   = 1'b0;
        lo_nxt_s   = 1'b0;
        if (rec_start) begin
          state_nxt_s = ST_REC;
          count_nxt_s = (ADDR_W+1)'(0);
          full_nxt_s  = 1'b0;
          cur_nxt_s   = live_s;
          dur_nxt_s   = DUR_W'(0);
          tick_clr_s  = 1'b1;
        end else if (play_start && (count_r != (ADDR_W+1)'(0))) begin
          state_nxt_s = ST_FETCH;
          idx_nxt_s   = ADDR_W'(0);
          tick_clr_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REC: begin
        note_nxt_s = 7'd0;
        hi_nxt_s   = 1'b0;
        lo_nxt_s   = 1'b0;
        if (rec_stop) begin
          state_nxt_s = ST_IDLE;
          if (dur_r != DUR_W'(0)) begin
            wr_en_s     = 1'b1;
            count_nxt_s = count_inc_s;
            full_nxt_s  = (count_inc_s == CNT_FULL);
          end else begin
            wr_en_s = 1'b0;
          end
        end else if (tick_s) begin
          if ((live_s == cur_r) && (dur_r != DUR_MAX)) begin
            dur_nxt_s = dur_r + DUR_W'(1);
          end else begin
            cur_nxt_s = live_s;
            dur_nxt_s = DUR_W'(1);
            if (dur_r != DUR_W'(0)) begin
              wr_en_s     = 1'b1;
              count_nxt_s = count_inc_s;
              // Last slot used: the event just started is dropped
              if (count_inc_s == CNT_FULL) begin
                state_nxt_s = ST_IDLE;
                full_nxt_s  = 1'b1;
              end else begin
                full_nxt_s  = 1'b0;
              end
            end else begin
              wr_en_s = 1'b0;
            end
          end
        end else begin
          state_nxt_s = ST_REC;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_PLAY;
        rem_nxt_s   = rd_data_s[DUR_W-1:0];
        note_nxt_s  = note_onehot(rd_data_s[EVT_W-1 -: NOTE_W]);
        hi_nxt_s    = (rd_data_s[DUR_W +: OCT_W] == OCT_HIGH);
        lo_nxt_s    = (rd_data_s[DUR_W +: OCT_W] == OCT_LOW);
      end
      ST_PLAY: begin
        if (rec_stop) begin
          state_nxt_s = ST_IDLE;
          note_nxt_s  = 7'd0;
          hi_nxt_s    = 1'b0;
          lo_nxt_s    = 1'b0;
        end else if (tick_s) begin
          rem_nxt_s = rem_r - DUR_W'(1);
          if (rem_r > DUR_W'(1)) begin
            state_nxt_s = ST_PLAY;
          end else if (last_s) begin
            state_nxt_s = ST_IDLE;
            note_nxt_s  = 7'd0;
            hi_nxt_s    = 1'b0;
            lo_nxt_s    = 1'b0;
          end else begin
            state_nxt_s = ST_FETCH;
            idx_nxt_s   = idx_r + ADDR_W'(1);
          end
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      count_r     <= (ADDR_W+1)'(0);
      full_r      <= 1'b0;
      cur_r       <= CODE_W'(0);
      dur_r       <= DUR_W'(0);
      idx_r       <= ADDR_W'(0);
      rem_r       <= DUR_W'(0);
      note_r      <= 7'd0;
      hi_r        <= 1'b0;
      lo_r        <= 1'b0;
      recording_r <= 1'b0;
      playing_r   <= 1'b0;
      cur_idx_r   <= ADDR_W'(0);
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      full_r      <= full_nxt_s;
      cur_r       <= cur_nxt_s;
      dur_r       <= dur_nxt_s;
      idx_r       <= idx_nxt_s;
      rem_r       <= rem_nxt_s;
      note_r      <= note_nxt_s;
      hi_r        <= hi_nxt_s;
      lo_r        <= lo_nxt_s;
      recording_r <= (state_nxt_s == ST_REC);
      playing_r   <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_PLAY);
      cur_idx_r   <= (state_nxt_s == ST_REC) ? count_nxt_s[ADDR_W-1:0] :
                     (state_nxt_s == ST_IDLE) ? ADDR_W'(0) : idx_nxt_s;
    end
  end

  // Read address is the next index so data is ready when FETCH loads it
  recorder_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (EVT_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (count_r[ADDR_W-1:0]),
    .wr_data ({cur_r, dur_r}),
    .rd_addr (idx_nxt_s),
    .rd_data (rd_data_s)
  );

  assign play_note   = note_r;
  assign play_higher = hi_r;
  assign play_lower  = lo_r;
  assign recording   = recording_r;
  assign playing     = playing_r;
  assign full        = full_r;
  assign count       = count_r;
  assign cur_idx     = cur_idx_r;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder (TICK_DIV=4): a DEPTH=32 instance for most
// scenarios and a DEPTH=4 instance sharing the same inputs for the full case.
module tb_note_recorder;

  logic       clk = 1'b0;
  logic       reset, rec_start, rec_stop, play_start, ishigher, islower;
  logic [6:0] notes;

  logic [6:0] play_note, pn4;
  logic       play_higher, play_lower, recording, playing, full;
  logic       ph4, pl4, rec4, ply4, full4;
  logic [5:0] count;
  logic [4:0] cur_idx;
  logic [2:0] cnt4;
  logic [1:0] idx4;

  int n_cmp = 0;
  int n_bad = 0;
  int n1, n2;

  always #5 clk = ~clk;

  note_recorder #(.DEPTH(32), .ADDR_W(5), .DUR_W(6), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .rec_start(rec_start), .rec_stop(rec_stop),
    .play_start(play_start), .notes(notes), .ishigher(ishigher), .islower(islower),
    .play_note(play_note), .play_higher(play_higher), .play_lower(play_lower),
    .recording(recording), .playing(playing), .full(full), .count(count),
    .cur_idx(cur_idx)
  );

  note_recorder #(.DEPTH(4), .ADDR_W(2), .DUR_W(6), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .rec_start(rec_start), .rec_stop(rec_stop),
    .play_start(play_start), .notes(notes), .ishigher(ishigher), .islower(islower),
    .play_note(pn4), .play_higher(ph4), .play_lower(pl4),
    .recording(rec4), .playing(ply4), .full(full4), .count(cnt4),
    .cur_idx(idx4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = rec_start, 1 = rec_stop, 2 = play_start
  task automatic pulse(input int which);
    case (which)
      0:       rec_start  = 1'b1;
      1:       rec_stop   = 1'b1;
      default: play_start = 1'b1;
    endcase
    step(1);
    rec_start  = 1'b0;
    rec_stop   = 1'b0;
    play_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rec_start = 1'b0; rec_stop = 1'b0; play_start = 1'b0;
    notes = 7'd0; ishigher = 1'b0; islower = 1'b0;
    step(3);
    check("reset_outs", 32'({play_note, play_higher, play_lower, recording, playing, full, count, cur_idx}), 32'd0);
    check("reset_outs4", 32'({pn4, ph4, pl4, rec4, ply4, full4, cnt4, idx4}), 32'd0);
    reset = 1'b1;
    step(1);

    // play_start with nothing stored
    pulse(2);
    check("play_empty", 32'(playing), 32'd0);

    // Basic record: note1 for 3 ticks, note3 high for 2 ticks
    notes = 7'b0000001;
    pulse(0);
    check("rec_flag", 32'(recording), 32'd1);
    step(12);
    notes = 7'b0000100; ishigher = 1'b1;
    step(8);
    pulse(1);
    notes = 7'd0; ishigher = 1'b0;
    check("basic_count", 32'(count), 32'd2);
    check("basic_rec_off", 32'(recording), 32'd0);
    check("basic_full", 32'(full), 32'd0);
    check("basic_mem0", 32'(dut.u_mem.mem_r[0]), 32'({3'd1, 2'd0, 6'd3}));
    check("basic_mem1", 32'(dut.u_mem.mem_r[1]), 32'({3'd3, 2'd1, 6'd2}));

    // Playback: 12 PLAY clocks + 1 FETCH hold for event 0, then 8 clocks for event 1
    pulse(2);
    check("play_flag", 32'(playing), 32'd1);
    check("fetch_note0", 32'(play_note), 32'd0);
    n1 = 0; n2 = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (!playing) break;
      if (play_note == 7'b0000001 && !play_higher && !play_lower) n1++;
      if (play_note == 7'b0000100 && play_higher && !play_lower) n2++;
    end
    check("play_ev0_clks", 32'(n1), 32'd13);
    check("play_ev1_clks", 32'(n2), 32'd8);
    check("play_end", 32'(playing), 32'd0);
    check("play_end_note", 32'(play_note), 32'd0);

    // Saturation: 70 ticks of note1 splits into 63 + 7
    notes = 7'b0000001;
    pulse(0);
    step(280);
    pulse(1);
    check("sat_count", 32'(count), 32'd2);
    check("sat_mem0", 32'(dut.u_mem.mem_r[0]), 32'({3'd1, 2'd0, 6'd63}));
    check("sat_mem1", 32'(dut.u_mem.mem_r[1]), 32'({3'd1, 2'd0, 6'd7}));

    // Full on the DEPTH=4 instance: new note every tick
    notes = 7'b0000001;
    pulse(0);
    step(4);
    for (int k = 2; k <= 5; k++) begin
      notes = 7'(1 << (k - 1));
      step(4);
    end
    check("full4_count", 32'(cnt4), 32'd4);
    check("full4_flag", 32'(full4), 32'd1);
    check("full4_rec_off", 32'(rec4), 32'd0);
    check("full4_mem3", 32'(dut4.u_mem.mem_r[3]), 32'({3'd4, 2'd0, 6'd1}));
    check("big_cur_idx", 32'(cur_idx), 32'd4);
    notes = 7'b0000001;
    step(8);
    check("full4_hold_count", 32'(cnt4), 32'd4);
    check("full4_hold_flag", 32'(full4), 32'd1);
    pulse(1);

    // Priority: lowest note wins, both octave switches mean middle
    notes = 7'b0110000; ishigher = 1'b1; islower = 1'b1;
    pulse(0);
    step(8);
    pulse(1);
    check("prio_count", 32'(count), 32'd1);
    check("prio_mem0", 32'(dut.u_mem.mem_r[0]), 32'({3'd5, 2'd0, 6'd2}));
    pulse(2);
    step(3);
    check("prio_play_note", 32'({play_note, play_higher, play_lower}), 32'({7'b0010000, 1'b0, 1'b0}));
    pulse(1);
    check("abort_playing", 32'(playing), 32'd0);
    check("abort_note", 32'(play_note), 32'd0);
    rec_start = 1'b1; play_start = 1'b1;
    step(1);
    rec_start = 1'b0; play_start = 1'b0;
    check("both_rec", 32'(recording), 32'd1);
    check("both_play", 32'(playing), 32'd0);

    // Reset mid-record after two events
    step(4);
    notes = 7'b0000001; ishigher = 1'b0; islower = 1'b0;
    step(4);
    notes = 7'b0000010;
    step(4);
    check("pre_rst_count", 32'(count), 32'd2);
    check("pre_rst_idx", 32'(cur_idx), 32'd2);
    reset = 1'b0;
    step(1);
    check("mid_rst_outs", 32'({play_note, play_higher, play_lower, recording, playing, full, count, cur_idx}), 32'd0);
    reset = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
